// File: rtl/axis_lrelu_config_scheduler_pkg.sv
// Shared definitions for the LReLU input-stream scheduler.
// Holds the scheduler state encoding, the tuser bit positions and the config
// beat counts that must agree with the engine's config state machine.
package axis_lrelu_config_scheduler_pkg;

    // Scheduler states
    typedef logic [1:0] state_t;
    localparam state_t CFG_FIRST = 2'd0;
    localparam state_t CFG_REST  = 2'd1;
    localparam state_t DATA      = 2'd2;

    // tuser bit positions on the engine input stream
    localparam int unsigned LRELU_I_IS_1X1 = 5;

    // Config packet composition: D beats + A beats + B beats
    localparam int unsigned LRELU_D_BEATS_3X3 = 1;
    localparam int unsigned LRELU_A_BEATS_3X3 = 2;
    localparam int unsigned LRELU_B_BEATS_3X3 = 18;
    localparam int unsigned LRELU_D_BEATS_1X1 = 1;
    localparam int unsigned LRELU_A_BEATS_1X1 = 6;
    localparam int unsigned LRELU_B_BEATS_1X1 = 6;

    localparam int unsigned LRELU_CONFIG_BEATS_3X3 =
        LRELU_D_BEATS_3X3 + LRELU_A_BEATS_3X3 + LRELU_B_BEATS_3X3;
    localparam int unsigned LRELU_CONFIG_BEATS_1X1 =
        LRELU_D_BEATS_1X1 + LRELU_A_BEATS_1X1 + LRELU_B_BEATS_1X1;

endpackage

// File: rtl/axis_lrelu_config_scheduler.sv
// axis_lrelu_config_scheduler
// Merges the config DMA stream and the conv output stream into the LReLU
// engine's input. Each iteration forwards one config packet (length chosen by
// the 1x1 tuser bit of its first beat), then conv data up to data tlast.
// The path is a zero-latency combinational mux; only sequencing state is
// registered.
//
// Ports
//   aclk, aresetn            clock, asynchronous active-low reset
//   s_cfg_*                  config source (valid/ready/data/user/last)
//   s_dat_*                  conv data source (valid/ready/data/user/last)
//   m_axis_*                 merged stream to the engine
//   cfg_error                sticky: config tlast disagreed with the beat count
//   iter_count               completed iterations (data tlast handshakes), wraps
module axis_lrelu_config_scheduler
    import axis_lrelu_config_scheduler_pkg::*;
#(
    parameter int unsigned WORD_WIDTH       = 3328,
    parameter int unsigned TUSER_WIDTH      = 8,
    parameter int unsigned I_IS_1X1         = LRELU_I_IS_1X1,
    parameter int unsigned CONFIG_BEATS_3X3 = LRELU_CONFIG_BEATS_3X3,
    parameter int unsigned CONFIG_BEATS_1X1 = LRELU_CONFIG_BEATS_1X1,
    parameter int unsigned ITER_BITS        = 16
) (
    input  logic                   aclk,
    input  logic                   aresetn,

    input  logic                   s_cfg_tvalid,
    output logic                   s_cfg_tready,
    input  logic [WORD_WIDTH-1:0]  s_cfg_tdata,
    input  logic [TUSER_WIDTH-1:0] s_cfg_tuser,
    input  logic                   s_cfg_tlast,

    input  logic                   s_dat_tvalid,
    output logic                   s_dat_tready,
    input  logic [WORD_WIDTH-1:0]  s_dat_tdata,
    input  logic [TUSER_WIDTH-1:0] s_dat_tuser,
    input  logic                   s_dat_tlast,

    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [WORD_WIDTH-1:0]  m_axis_tdata,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,
    output logic                   m_axis_tlast,

    output logic                   cfg_error,
    output logic [ITER_BITS-1:0]   iter_count
);

    localparam int unsigned CNT_W = $clog2(CONFIG_BEATS_3X3);

    // cnt holds the config beats still to come after the current one, so the
    // first beat loads (total - 2) and the final beat sees zero.
    localparam logic [CNT_W-1:0] CNT_INIT_3X3 = CNT_W'(CONFIG_BEATS_3X3 - 2);
    localparam logic [CNT_W-1:0] CNT_INIT_1X1 = CNT_W'(CONFIG_BEATS_1X1 - 2);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 cfg_error_q, cfg_error_d;
    logic [ITER_BITS-1:0] iter_q, iter_d;

    logic sel_cfg;
    logic cfg_hs;
    logic dat_hs;
    logic cfg_final;

    assign sel_cfg = (state_q != DATA);

    // Output mux. Valid/ready are forced low while reset is asserted so the
    // engine and both sources see an idle link immediately.
    always_comb begin
        m_axis_tvalid = 1'b0;
        s_cfg_tready  = 1'b0;
        s_dat_tready  = 1'b0;
        if (sel_cfg) begin
            m_axis_tdata = s_cfg_tdata;
            m_axis_tuser = s_cfg_tuser;
            m_axis_tlast = 1'b0;
        end else begin
            m_axis_tdata = s_dat_tdata;
            m_axis_tuser = s_dat_tuser;
            m_axis_tlast = s_dat_tlast;
        end
        if (aresetn) begin
            m_axis_tvalid = sel_cfg ? s_cfg_tvalid : s_dat_tvalid;
            s_cfg_tready  = sel_cfg & m_axis_tready;
            s_dat_tready  = ~sel_cfg & m_axis_tready;
        end
    end

    assign cfg_hs    = s_cfg_tvalid & s_cfg_tready;
    assign dat_hs    = s_dat_tvalid & s_dat_tready;
    assign cfg_final = (state_q == CFG_REST) && (cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cfg_error_d = cfg_error_q;
        iter_d      = iter_q;

        case (state_q)
            CFG_FIRST: begin
                if (cfg_hs) begin
                    // Packet length comes from the live tuser of this beat.
                    cnt_d   = s_cfg_tuser[I_IS_1X1] ? CNT_INIT_1X1 : CNT_INIT_3X3;
                    state_d = CFG_REST;
                end
            end
            CFG_REST: begin
                if (cfg_hs) begin
                    if (cnt_q == '0) begin
                        state_d = DATA;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            DATA: begin
                if (dat_hs && s_dat_tlast) begin
                    state_d = CFG_FIRST;
                    iter_d  = iter_q + 1'b1;
                end
            end
            default: begin
                state_d = CFG_FIRST;
            end
        endcase

        // The beat count alone sequences the packet; tlast is only audited.
        if (cfg_hs && (s_cfg_tlast != cfg_final)) begin
            cfg_error_d = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= CFG_FIRST;
            cnt_q       <= '0;
            cfg_error_q <= 1'b0;
            iter_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cfg_error_q <= cfg_error_d;
            iter_q      <= iter_d;
        end
    end

    assign cfg_error  = cfg_error_q;
    assign iter_count = iter_q;

endmodule

// File: tb/tb_axis_lrelu_config_scheduler.sv
// Self-checking bench for axis_lrelu_config_scheduler.
// Stimulus is built as whole packets; the expected merged stream is the
// ordered concatenation config(tlast forced 0) + data, each entry annotated
// with the sticky error / iteration count that must hold after it is taken.
module tb_axis_lrelu_config_scheduler;

    localparam int W = 32;
    localparam int U = 8;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          s_cfg_tvalid = 1'b0;
    logic          s_cfg_tready;
    logic [W-1:0]  s_cfg_tdata = '0;
    logic [U-1:0]  s_cfg_tuser = '0;
    logic          s_cfg_tlast = 1'b0;
    logic          s_dat_tvalid = 1'b0;
    logic          s_dat_tready;
    logic [W-1:0]  s_dat_tdata = '0;
    logic [U-1:0]  s_dat_tuser = '0;
    logic          s_dat_tlast = 1'b0;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic [W-1:0]  m_axis_tdata;
    logic [U-1:0]  m_axis_tuser;
    logic          m_axis_tlast;
    logic          cfg_error;
    logic [15:0]   iter_count;

    always #5 aclk = ~aclk;

    axis_lrelu_config_scheduler #(
        .WORD_WIDTH  (W),
        .TUSER_WIDTH (U)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_cfg_tvalid  (s_cfg_tvalid),
        .s_cfg_tready  (s_cfg_tready),
        .s_cfg_tdata   (s_cfg_tdata),
        .s_cfg_tuser   (s_cfg_tuser),
        .s_cfg_tlast   (s_cfg_tlast),
        .s_dat_tvalid  (s_dat_tvalid),
        .s_dat_tready  (s_dat_tready),
        .s_dat_tdata   (s_dat_tdata),
        .s_dat_tuser   (s_dat_tuser),
        .s_dat_tlast   (s_dat_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .cfg_error     (cfg_error),
        .iter_count    (iter_count)
    );

    typedef struct {
        logic [W-1:0] data;
        logic [U-1:0] user;
        logic         last;
    } beat_t;

    typedef struct {
        logic [W-1:0] data;
        logic [U-1:0] user;
        logic         last;
        bit           is_cfg;
        bit           err_after;
        int           iter_after;
        bit           cfg_next;
    } exp_t;

    beat_t cfg_src[$];
    beat_t dat_src[$];
    beat_t pkt[$];
    exp_t  exp_q[$];
    exp_t  cur_e;

    int total = 0;
    int bad   = 0;
    int bp    = 0;      // percent of cycles a valid/ready is withheld
    int tag   = 1;

    // Generation-side model state
    bit gen_err  = 0;
    int gen_iter = 0;
    // Observation-side model state (reflects handshakes already taken)
    bit m_err       = 0;
    int m_iter      = 0;
    bit m_cfg_phase = 1;
    int n_out_cfg   = 0;
    int n_out_dat   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic gen_cfg(input bit is1x1, input int tlast_pos);
        beat_t b;
        int n;
        n = is1x1 ? 13 : 21;
        pkt.delete();
        for (int i = 0; i < n; i++) begin
            b.data = W'(tag);
            tag++;
            b.user = U'($urandom_range(0, 255));
            if (i == 0) b.user[5] = is1x1;
            b.last = (i + 1 == tlast_pos);
            pkt.push_back(b);
        end
    endtask

    task automatic push_cfg_src(input int lo);
        for (int i = lo; i < pkt.size(); i++) cfg_src.push_back(pkt[i]);
    endtask

    task automatic push_cfg_exp();
        exp_t e;
        int n;
        n = pkt.size();
        for (int i = 0; i < n; i++) begin
            if (pkt[i].last != (i == n - 1)) gen_err = 1;
            e.data       = pkt[i].data;
            e.user       = pkt[i].user;
            e.last       = 1'b0;
            e.is_cfg     = 1;
            e.err_after  = gen_err;
            e.iter_after = gen_iter;
            e.cfg_next   = (i != n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_data(input int n);
        beat_t b;
        exp_t  e;
        for (int i = 0; i < n; i++) begin
            b.data = W'(tag);
            tag++;
            b.user = U'($urandom_range(0, 255));
            b.last = (i == n - 1);
            dat_src.push_back(b);
            if (b.last) gen_iter++;
            e.data       = b.data;
            e.user       = b.user;
            e.last       = b.last;
            e.is_cfg     = 0;
            e.err_after  = gen_err;
            e.iter_after = gen_iter;
            e.cfg_next   = b.last;
            exp_q.push_back(e);
        end
    endtask

    task automatic run_iter(input bit is1x1, input int ndata, input int tlast_pos);
        gen_cfg(is1x1, tlast_pos);
        push_cfg_src(0);
        push_cfg_exp();
        push_data(ndata);
    endtask

    task automatic settle();
        @(posedge aclk);
        #2;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int c;
        c = 0;
        while ((exp_q.size() > 0 || cfg_src.size() > 0 || dat_src.size() > 0) && c < budget) begin
            @(posedge aclk);
            c++;
        end
        check(name, 64'(exp_q.size()), 0);
        repeat (2) @(posedge aclk);
        #2;
    endtask

    task automatic model_reset();
        cfg_src.delete();
        dat_src.delete();
        exp_q.delete();
        gen_err     = 0;
        gen_iter    = 0;
        m_err       = 0;
        m_iter      = 0;
        m_cfg_phase = 1;
        s_cfg_tvalid = 1'b0;
        s_dat_tvalid = 1'b0;
    endtask

    // Compare at negedge, drive sources/sink 1 ns after posedge.
    initial begin : clkproc
        bit cfg_hs;
        bit dat_hs;
        forever begin
            @(negedge aclk);
            cfg_hs = 0;
            dat_hs = 0;
            if (!aresetn) begin
                check("rst_m_tvalid", m_axis_tvalid, 0);
                check("rst_s_cfg_tready", s_cfg_tready, 0);
                check("rst_s_dat_tready", s_dat_tready, 0);
            end else begin
                check("cfg_error", cfg_error, m_err);
                check("iter_count", iter_count, 64'(m_iter[15:0]));
                check("m_tvalid_route", m_axis_tvalid, m_cfg_phase ? s_cfg_tvalid : s_dat_tvalid);
                check("s_cfg_tready", s_cfg_tready, m_cfg_phase & m_axis_tready);
                check("s_dat_tready", s_dat_tready, !m_cfg_phase & m_axis_tready);
                cfg_hs = s_cfg_tvalid & s_cfg_tready;
                dat_hs = s_dat_tvalid & s_dat_tready;
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        cur_e = exp_q.pop_front();
                        check("m_tdata", m_axis_tdata, cur_e.data);
                        check("m_tuser", m_axis_tuser, cur_e.user);
                        check("m_tlast", m_axis_tlast, cur_e.last);
                        if (cur_e.is_cfg) n_out_cfg++;
                        else n_out_dat++;
                        m_err       = cur_e.err_after;
                        m_iter      = cur_e.iter_after;
                        m_cfg_phase = cur_e.cfg_next;
                    end
                end
            end
            @(posedge aclk);
            #1;
            if (cfg_hs && cfg_src.size() > 0) void'(cfg_src.pop_front());
            if (dat_hs && dat_src.size() > 0) void'(dat_src.pop_front());
            if (!aresetn) begin
                s_cfg_tvalid = 1'b0;
                s_dat_tvalid = 1'b0;
            end else begin
                // A valid that was not taken stays up with the same beat.
                if (!(s_cfg_tvalid && !cfg_hs))
                    s_cfg_tvalid = (cfg_src.size() > 0) && ($urandom_range(0, 99) >= bp);
                if (!(s_dat_tvalid && !dat_hs))
                    s_dat_tvalid = (dat_src.size() > 0) && ($urandom_range(0, 99) >= bp);
            end
            if (cfg_src.size() > 0) begin
                s_cfg_tdata = cfg_src[0].data;
                s_cfg_tuser = cfg_src[0].user;
                s_cfg_tlast = cfg_src[0].last;
            end
            if (dat_src.size() > 0) begin
                s_dat_tdata = dat_src[0].data;
                s_dat_tuser = dat_src[0].user;
                s_dat_tlast = dat_src[0].last;
            end
            m_axis_tready = ($urandom_range(0, 99) >= bp);
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int c;
        int base;

        // Reset state
        repeat (3) @(posedge aclk);
        #3 aresetn = 1'b1;
        settle();
        check("reset_iter_count", iter_count, 0);
        check("reset_cfg_error", cfg_error, 0);

        // 1: plain 3x3 iteration, no backpressure
        bp = 0;
        run_iter(0, 50, 21);
        wait_drain("t1_drain", 500);
        check("t1_cfg_beats", 64'(n_out_cfg), 21);
        check("t1_dat_beats", 64'(n_out_dat), 50);
        check("t1_iter_count", iter_count, 1);
        check("t1_cfg_error", cfg_error, 0);

        // 2: 1x1 packet, early 14th config beat must wait for DATA to finish
        base = n_out_cfg;
        gen_cfg(1, 13);
        push_cfg_src(0);
        push_cfg_exp();
        gen_cfg(0, 21);
        cfg_src.push_back(pkt[0]);
        c = 0;
        while (cfg_src.size() > 1 && c < 200) begin
            @(posedge aclk);
            c++;
        end
        repeat (5) @(posedge aclk);
        #2;
        check("t2_cfg_beats", 64'(n_out_cfg - base), 13);
        check("t2_cfg_blocked", s_cfg_tready, 0);
        check("t2_dat_ready", s_dat_tready, 1);
        push_data(4);
        push_cfg_src(1);
        push_cfg_exp();
        push_data(6);
        wait_drain("t2_drain", 500);
        check("t2_iter_count", iter_count, 3);

        // 3: random backpressure, mixed modes, from a fresh reset
        @(posedge aclk);
        #3 aresetn = 1'b0;
        model_reset();
        repeat (2) @(posedge aclk);
        #3 aresetn = 1'b1;
        bp = 40;
        run_iter(0, 20, 21);
        run_iter(1, 7, 13);
        run_iter(0, 12, 21);
        wait_drain("t3_drain", 2000);
        check("t3_iter_count", iter_count, 3);
        check("t3_cfg_error", cfg_error, 0);

        // 4: early config tlast on beat 20 of 21
        bp = 0;
        base = n_out_cfg;
        run_iter(0, 5, 20);
        wait_drain("t4_drain", 500);
        check("t4_cfg_beats", 64'(n_out_cfg - base), 21);
        check("t4_cfg_error", cfg_error, 1);
        check("t4_iter_count", iter_count, 4);
        run_iter(1, 3, 13);
        wait_drain("t4b_drain", 500);
        check("t4_error_sticky", cfg_error, 1);

        // 6: reset during DATA beat 10
        base = n_out_dat;
        run_iter(0, 50, 21);
        c = 0;
        while (n_out_dat < base + 10 && c < 500) begin
            @(posedge aclk);
            c++;
        end
        @(posedge aclk);
        #3 aresetn = 1'b0;
        #1;
        check("t6_async_tvalid", m_axis_tvalid, 0);
        check("t6_async_dat_tready", s_dat_tready, 0);
        model_reset();
        repeat (3) @(posedge aclk);
        #3 aresetn = 1'b1;
        settle();
        check("t6_iter_count", iter_count, 0);
        check("t6_cfg_error", cfg_error, 0);
        base = n_out_cfg;
        run_iter(1, 5, 13);
        c = 0;
        while (n_out_cfg == base && n_out_dat >= 0 && c < 100) begin
            @(posedge aclk);
            c++;
        end
        #2;
        check("t6_first_from_cfg", 64'(n_out_cfg - base), 1);
        wait_drain("t6_drain", 500);
        check("t6_iter_after", iter_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
